// File: rtl/gpio_checkpoint_reporter.sv
// Checkpoint producer for the GPIO pads: buffers (code, value) posts and drives them data-first.
// Optional CHECKPOINT_TIMESTAMP_EN: code 6'h3F stores a free-running cycle count instead of the value.
module gpio_checkpoint_reporter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SETUP = 2,
   parameter int unsigned DWELL = 16
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        enable,
   input  logic        post_valid,
   output logic        post_ready,
   input  logic [5:0]  post_check,
   input  logic [31:0] post_data,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb,
   output logic        busy
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned MAXC = (SETUP > DWELL) ? SETUP : DWELL;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHOW
   } state_e;

   logic [37:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          ready_q;
   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   data_q;
   logic [5:0]    code_q;
   logic [5:0]    pend_q;

   logic          push;
   logic          pop;
   logic          show_done;
   logic [37:0]   head;
   logic [31:0]   wdata;

   assign push      = post_valid && ready_q;
   assign show_done = (state_q == ST_SHOW) && (cnt_q == DWELL_LAST);
   assign pop       = ((state_q == ST_IDLE) || show_done) && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];

`ifdef CHECKPOINT_TIMESTAMP_EN
   logic [31:0] ts_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
      end
   end

   assign wdata = (post_check == 6'h3F) ? ts_q : post_data;
`else
   assign wdata = post_data;
`endif

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {post_check, wdata};
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
      end
   end

   // A pop blanks the code lanes first when the new code would be indistinguishable.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         code_q  <= '0;
         pend_q  <= '0;
      end else if (pop) begin
         data_q  <= head[31:0];
         pend_q  <= head[37:32];
         if (head[37:32] == code_q) begin
            code_q <= 6'h00;
         end
         cnt_q   <= '0;
         state_q <= ST_SETUP;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
            end
            ST_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  code_q  <= pend_q;
                  cnt_q   <= '0;
                  state_q <= ST_SHOW;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign post_ready = ready_q;
   assign io_out     = {code_q, data_q};
   assign io_oeb     = {38{~enable}};
   assign busy       = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_checkpoint_reporter.sv
// Directed bench for gpio_checkpoint_reporter with default parameters.
// Covers ordering, backpressure, repeat gap, enable, mid-run reset and code 6'h3F.
module tb_gpio_checkpoint_reporter;
   logic        clock;
   logic        resetb;
   logic        enable;
   logic        post_valid;
   logic        post_ready;
   logic [5:0]  post_check;
   logic [31:0] post_data;
   logic [37:0] io_out;
   logic [37:0] io_oeb;
   logic        busy;

   int errors;
   int checks;
   int cyc;

   gpio_checkpoint_reporter dut (
      .clock      (clock),
      .resetb     (resetb),
      .enable     (enable),
      .post_valid (post_valid),
      .post_ready (post_ready),
      .post_check (post_check),
      .post_data  (post_data),
      .io_out     (io_out),
      .io_oeb     (io_oeb),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic set_post(input logic v, input logic [5:0] c, input logic [31:0] d);
      post_valid = v;
      post_check = c;
      post_data  = d;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [5:0]  c2 [5];
   logic [31:0] v2 [5];
   int e, g, h, j, k, t, p;
   logic [31:0] ts_exp;

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      c2 = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
      v2 = '{32'h19, 32'h0d, 32'h12bc, 32'h5d, 32'h08};
      resetb = 1'b0;
      enable = 1'b0;
      set_post(1'b0, 6'h00, 32'h0);

      step();
      step();
      check("rst_io_out", io_out, 0);
      check("rst_busy", busy, 0);
      check("rst_oeb_dis", io_oeb, {38{1'b1}});
      enable = 1'b1;
      #1;
      check("rst_oeb_en", io_oeb, 0);
      resetb = 1'b1;
      step();
      check("rel_ready", post_ready, 1);
      check("rel_busy", busy, 0);

      // ordering and latency
      e = cyc + 1;
      set_post(1'b1, 6'h0a, 32'h0);
      step();
      set_post(1'b1, 6'h01, 32'hdcba7cf9);
      step();
      set_post(1'b0, 6'h00, 32'h0);
      check("t1_data_first", io_out[31:0], 0);
      check("t1_code_e1", io_out[37:32], 0);
      check("t1_busy", busy, 1);
      step();
      check("t1_code_e2", io_out[37:32], 0);
      step();
      check("t1_code_e3", io_out[37:32], 6'h0a);
      while (cyc < e + 21) begin
         step();
         if (io_out[37:32] == 6'h01)
            check("t1_order", io_out[31:0], 32'hdcba7cf9);
         if (cyc == e + 18) check("t1_data_e18", io_out[31:0], 0);
         if (cyc == e + 19) check("t1_data_e19", io_out[31:0], 32'hdcba7cf9);
         if (cyc == e + 20) check("t1_code_e20", io_out[37:32], 6'h0a);
         if (cyc == e + 21) check("t1_code_e21", io_out[37:32], 6'h01);
      end

      // backpressure: fill while 0x01 is still dwelling
      step_to(e + 24);
      set_post(1'b1, c2[0], v2[0]);
      for (int i = 1; i < 5; i++) begin
         step();
         set_post(1'b1, c2[i], v2[i]);
      end
      check("t2_full_ready", post_ready, 0);
      step_to(e + 36);
      check("t2_held_ready", post_ready, 0);
      check("t2_code_hold", io_out[37:32], 6'h01);
      step();
      check("t2_ready_back", post_ready, 1);
      step();
      set_post(1'b0, 6'h00, 32'h0);
      check("t2_refull", post_ready, 0);
      for (int i = 0; i < 5; i++) begin
         p = e + 37 + i * 18;
         step_to(p);
         check($sformatf("t2_data%0d", i), io_out[31:0], v2[i]);
         step_to(p + 2);
         check($sformatf("t2_code%0d", i), io_out[37:32], c2[i]);
      end
      step_to(e + 126);
      check("t2_busy_last", busy, 1);
      step();
      check("t2_busy_fall", busy, 0);

      // repeat gap
      g = cyc + 1;
      set_post(1'b1, 6'h03, 32'h0d);
      step();
      step();
      set_post(1'b0, 6'h00, 32'h0);
      check("t3_hold_old", io_out[37:32], 6'h06);
      step_to(g + 3);
      check("t3_code_a", io_out[37:32], 6'h03);
      step_to(g + 18);
      check("t3_code_pre", io_out[37:32], 6'h03);
      step();
      check("t3_gap0", io_out[37:32], 6'h00);
      check("t3_data0", io_out[31:0], 32'h0d);
      step();
      check("t3_gap1", io_out[37:32], 6'h00);
      step();
      check("t3_code_b", io_out[37:32], 6'h03);
      check("t3_data1", io_out[31:0], 32'h0d);
      step_to(g + 37);
      check("t3_idle", busy, 0);

      // enable gating
      enable = 1'b0;
      #1;
      check("t4_oeb_off", io_oeb, {38{1'b1}});
      h = cyc + 1;
      set_post(1'b1, 6'h11, 32'ha5a5);
      step();
      set_post(1'b0, 6'h00, 32'h0);
      step_to(h + 3);
      check("t4_out_hidden", io_out, {6'h11, 32'ha5a5});
      check("t4_oeb_still", io_oeb, {38{1'b1}});
      enable = 1'b1;
      #1;
      check("t4_oeb_on", io_oeb, 0);
      check("t4_out_shown", io_out, {6'h11, 32'ha5a5});
      step_to(h + 19);
      check("t4_idle", busy, 0);

      // reset during SHOW with two queued
      j = cyc + 1;
      set_post(1'b1, 6'h21, 32'h1);
      step();
      set_post(1'b1, 6'h22, 32'h2);
      step();
      set_post(1'b1, 6'h23, 32'h3);
      step();
      set_post(1'b0, 6'h00, 32'h0);
      step_to(j + 10);
      check("t5_pre_code", io_out[37:32], 6'h21);
      #2;
      resetb = 1'b0;
      #1;
      check("t5_rst_out", io_out, 0);
      check("t5_rst_busy", busy, 0);
      #1;
      resetb = 1'b1;
      set_post(1'b1, 6'h10, 32'h08);
      k = cyc + 1;
      step();
      set_post(1'b0, 6'h00, 32'h0);
      step();
      check("t5_data", io_out[31:0], 32'h08);
      check("t5_code_old", io_out[37:32], 6'h00);
      step_to(k + 3);
      check("t5_code", io_out[37:32], 6'h10);
      step_to(k + 19);
      check("t5_no_stale", busy, 0);
      check("t5_final", io_out, {6'h10, 32'h08});

      // code 6'h3F
      t = cyc + 1;
      set_post(1'b1, 6'h3F, 32'hFFFFFFFF);
      step();
      set_post(1'b0, 6'h00, 32'h0);
      step();
`ifdef CHECKPOINT_TIMESTAMP_EN
      ts_exp = 32'(t - k);
`else
      ts_exp = 32'hFFFFFFFF;
`endif
      check("t6_data", io_out[31:0], ts_exp);
      step_to(t + 19);
      check("t6_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gpio_checkpoint_reporter.md
Name: gpio_checkpoint_reporter

Overview:
- Hardware producer for the management-SoC checkpoint protocol on the user GPIO pads: a 6-bit check code on mprj_io[37:32] and a 32-bit value on mprj_io[31:0].
- Accepts (code, value) posts from a management-side register, buffers them, and drives them onto the pads with guaranteed data-before-code ordering and a minimum dwell per checkpoint.
- Lets DV monitors that wait on the code and then sample the value see each checkpoint stably, without firmware delay loops.

Parameters:
- DEPTH, 4, post FIFO entries (power of 2, ≥2)
- SETUP, 2, cycles value lanes lead code lanes (≥1)
- DWELL, 16, cycles a code is held before the next pop (≥1)

Ports:
- clock  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- enable  in  1  drive pads when 1; all pads high-Z when 0
- post_valid  in  1  post request
- post_ready  out  1  FIFO can accept; equals !full, registered
- post_check  in  6  check code
- post_data  in  32  value
- io_out  out  38  pad output data, {check[5:0], data[31:0]}
- io_oeb  out  38  active-low output enable, all bits = ~enable
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Accept rule: post accepted at a rising edge where post_valid && post_ready; entry = {post_check, post_data}.
- Full FIFO: post_ready = 0. No push while full, even if a pop occurs in the same cycle; post_ready rises the cycle after the pop.
- Simultaneous push and pop when not full: both occur, count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty at edge P, pop the head; data lanes <= entry data at P; go to SETUP.
  - SETUP: count SETUP cycles; code lanes <= entry code at edge P+SETUP; go to SHOW.
  - SHOW: count DWELL cycles; return to IDLE at edge P+SETUP+DWELL. The next pop is no earlier than that edge.
- Repeat gap: if the popped code equals the code currently shown, code lanes go to 6'h00 at edge P, then take the new code at P+SETUP. Otherwise code lanes hold the old code during SETUP.
- Latency: an entry written into an empty, idle FIFO at edge E0 is popped at E0+1.
- Output stability: io_out never changes outside these edges. Data lanes change only at a pop. Code lanes change only at P (repeat gap) or P+SETUP.
- enable affects io_oeb only. The FSM and FIFO run regardless of enable.
- Reset (async, any state, including mid-SETUP/SHOW):
  - io_out = 0, FSM = IDLE, FIFO empty.
  - post_ready = 1 on the first edge after release; busy = 0.
  - io_oeb follows enable combinationally.
- Width rules: all counters saturate-free, sized clog2(max(SETUP,DWELL)+1). FIFO pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: CHECKPOINT_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter is present: 0 at reset, increments every clock, wraps at 2^32.
  - A post with post_check == 6'h3F stores the counter value at the accept edge in place of post_data.
- Undefined: no counter is present; 6'h3F is an ordinary code whose post_data is stored as given.

Test Plan:
- Ordering and latency: reset, enable=1, post (0x0a, 0) at E0 then (0x01, 0xdcba7cf9) at E0+1 → io_out[31:0] = 0 at E0+1, io_out[37:32] = 0x0a at E0+3. Data lanes = 0xdcba7cf9 at E0+19, code lanes = 0x01 at E0+21. Code lanes never equal 0x01 while data lanes differ from 0xdcba7cf9.
- Backpressure: post 5 entries back-to-back with DEPTH=4 → post_ready = 0 after the 4th accept and the 5th is held. All 5 are shown in order: codes 0x02..0x06, values 0x19, 0x0d, 0x12bc, 0x5d, 0x08. busy falls after the last dwell.
- Repeat gap: post (0x03, 0x0d) then (0x03, 0x0d) → code lanes go 0x03 → 0x00 → 0x03. The 0x00 phase is exactly SETUP=2 cycles; data lanes stay 0x0d.
- Enable: enable=0 with posts in flight → io_oeb = all ones, FSM still progresses. Raising enable → io_oeb = 0 combinationally and io_out shows the current checkpoint.
- Reset mid-operation: assert resetb low during SHOW with 2 entries queued → io_out = 0 and busy = 0 immediately. After release, post (0x10, 0x08) → shown with nominal latency, and none of the old entries appear.
- With CHECKPOINT_TIMESTAMP_EN: post (0x3F, 0xFFFFFFFF) accepted at cycle 100 after reset → data lanes show 100 (0x64), not 0xFFFFFFFF. Without the macro, data lanes show 0xFFFFFFFF.
